// File: rtl/mci_mcu_mc_trace_buffer_pkg.sv
// -----------------------------------------------------------------------------
// mci_mcu_mc_trace_buffer_pkg
// Shared types and constants for the MCI multi-channel trace buffer:
//   - trc_state_e : capture FSM encoding (3 bits, visible in STATUS[4:2])
//   - trc_pkt_t   : one stored packet, dword0 in bits [31:0] .. dword3 in [127:96]
//   - CSR byte offsets and CTRL bit positions
//   - pkt_dword() : extracts one dword of a stored packet
// -----------------------------------------------------------------------------
package mci_mcu_mc_trace_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_POST    = 3'd3,
    ST_STOPPED = 3'd4
  } trc_state_e;

  // dword3 of a packet
  typedef struct packed {
    logic [22:0] rsvd;
    logic [1:0]  chan_id;
    logic        intr;
    logic [4:0]  ecause;
    logic        exc;
  } trc_info_t;

  // Declared MSB-first so that insn lands in dword0
  typedef struct packed {
    trc_info_t   info;
    logic [31:0] tval;
    logic [31:0] addr;
    logic [31:0] insn;
  } trc_pkt_t;

  localparam logic [5:0] CSR_CTRL      = 6'h00;
  localparam logic [5:0] CSR_STATUS    = 6'h04;
  localparam logic [5:0] CSR_CONFIG    = 6'h08;
  localparam logic [5:0] CSR_WR_PTR    = 6'h0C;
  localparam logic [5:0] CSR_RD_PTR    = 6'h10;
  localparam logic [5:0] CSR_DATA      = 6'h14;
  localparam logic [5:0] CSR_TRIG_ADDR = 6'h18;
  localparam logic [5:0] CSR_POST_CNT  = 6'h1C;
  localparam logic [5:0] CSR_DROP_CNT  = 6'h20;

  localparam int CTRL_ARM          = 0;
  localparam int CTRL_STOP_ON_FULL = 1;
  localparam int CTRL_TRIG_EN      = 2;
  localparam int CTRL_CLEAR        = 3;

  function automatic logic [31:0] pkt_dword(input trc_pkt_t pkt, input logic [1:0] idx);
    return pkt[32*int'(idx) +: 32];
  endfunction

endpackage

// File: rtl/mci_mcu_mc_trace_buffer_rr_arb.sv
// -----------------------------------------------------------------------------
// mci_trace_rr_arb
// Round-robin arbiter over N trace channels (N = 1..4).
//   clk, rst_b  : clock, async active-low reset
//   adv_i       : the grant was consumed; move priority past the winner
//   clr_i       : return priority to channel 0
//   req_i       : per-channel request
//   gnt_o       : one-hot grant
//   gnt_idx_o   : index of the granted channel
//   drop_o      : number of requesting channels that lost this cycle
// -----------------------------------------------------------------------------
module mci_trace_rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         adv_i,
  input  logic         clr_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [1:0]   gnt_idx_o,
  output logic [2:0]   drop_o
);

  logic [1:0] rr_q, rr_d;
  logic       found;
  logic [2:0] req_cnt;

  // Scan from the current priority channel, wrapping modulo N
  always_comb begin
    int c;
    c         = 0;
    found     = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    req_cnt   = '0;
    for (int i = 0; i < N; i++) begin
      c = int'(rr_q) + i;
      if (c >= N) c = c - N;
      if (!found && req_i[c]) begin
        found     = 1'b1;
        gnt_o[c]  = 1'b1;
        gnt_idx_o = 2'(c);
      end
      req_cnt = req_cnt + 3'(req_i[i]);
    end
    drop_o = found ? (req_cnt - 3'd1) : 3'd0;
  end

  always_comb begin
    rr_d = rr_q;
    if (clr_i)
      rr_d = '0;
    else if (adv_i && found)
      rr_d = (int'(gnt_idx_o) == N - 1) ? 2'd0 : gnt_idx_o + 2'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) rr_q <= '0;
    else        rr_q <= rr_d;
  end

endmodule

// File: rtl/mci_mcu_mc_trace_buffer.sv
// -----------------------------------------------------------------------------
// mci_mcu_mc_trace_buffer
// Captures retired-instruction trace packets from up to NUM_CHANNELS MCU trace
// ports into a NUM_TRACE_ENTRIES x 4-dword buffer, with trigger/post-count and
// wrap or stop-on-full capture, read back through a single-cycle CSR port.
//   clk, rst_b          : clock, async active-low reset
//   debug_en            : gates CSR access and trace capture
//   trc_*               : per-channel packet fields (flat, channel-major)
//   reg_req/wr/addr/wdata, reg_rdata, reg_err : combinational CSR port
//   trig_hit            : one-cycle pulse after the trigger packet is stored
//   capture_done        : high while the FSM is STOPPED
// -----------------------------------------------------------------------------
module mci_mcu_mc_trace_buffer
  import mci_mcu_mc_trace_buffer_pkg::*;
#(
  parameter int NUM_CHANNELS      = 2,
  parameter int NUM_TRACE_ENTRIES = 64,
  parameter int PKT_DWORDS        = 4,
  parameter int DROP_CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      debug_en,
  input  logic [NUM_CHANNELS-1:0]   trc_valid,
  input  logic [NUM_CHANNELS*32-1:0] trc_insn,
  input  logic [NUM_CHANNELS*32-1:0] trc_addr,
  input  logic [NUM_CHANNELS*32-1:0] trc_tval,
  input  logic [NUM_CHANNELS-1:0]   trc_exc,
  input  logic [NUM_CHANNELS*5-1:0] trc_ecause,
  input  logic [NUM_CHANNELS-1:0]   trc_intr,
  input  logic                      reg_req,
  input  logic                      reg_wr,
  input  logic [5:0]                reg_addr,
  input  logic [31:0]               reg_wdata,
  output logic [31:0]               reg_rdata,
  output logic                      reg_err,
  output logic                      trig_hit,
  output logic                      capture_done
);

  localparam int PTR_W  = $clog2(NUM_TRACE_ENTRIES * PKT_DWORDS);
  localparam int SLOT_W = PTR_W - 2;

  trc_state_e              state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                    valid_q, valid_d, wrapped_q, wrapped_d;
  logic                    sof_q, sof_d, trig_en_q, trig_en_d;
  logic [31:0]             trig_addr_q, trig_addr_d;
  logic [15:0]             post_cnt_q, post_cnt_d, post_ctr_q, post_ctr_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]     drop_sum;
  logic                    trig_hit_q, trig_hit_d;
  trc_pkt_t                mem_q [NUM_TRACE_ENTRIES];

  logic [NUM_CHANNELS-1:0] arb_gnt;
  logic [1:0]              arb_idx;
  logic [2:0]              arb_drop;
  logic                    capturing, wr_en, last_slot;
  logic [SLOT_W-1:0]       wr_slot;
  trc_pkt_t                wr_pkt;

  logic                    mapped, ro, csr_ok, wr_ok, data_rd, clear_cmd, arm_cmd;
  logic [31:0]             rdata_v;

  // ---------------------------------------------------------------- arbiter
  mci_trace_rr_arb #(.N(NUM_CHANNELS)) u_arb (
    .clk       (clk),
    .rst_b     (rst_b),
    .adv_i     (wr_en),
    .clr_i     (clear_cmd),
    .req_i     (trc_valid),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .drop_o    (arb_drop)
  );

  assign capturing = (state_q == ST_ARMED) || (state_q == ST_CAPTURE) || (state_q == ST_POST);
  // A clear in the same cycle wins over any incoming packet
  assign wr_en     = debug_en && capturing && (|arb_gnt) && !clear_cmd;
  assign wr_slot   = wr_ptr_q[PTR_W-1:2];
  assign last_slot = (wr_slot == SLOT_W'(NUM_TRACE_ENTRIES - 1));

  always_comb begin
    wr_pkt              = '0;
    wr_pkt.insn         = trc_insn[32*int'(arb_idx) +: 32];
    wr_pkt.addr         = trc_addr[32*int'(arb_idx) +: 32];
    wr_pkt.tval         = trc_tval[32*int'(arb_idx) +: 32];
    wr_pkt.info.chan_id = arb_idx;
    wr_pkt.info.intr    = trc_intr[arb_idx];
    wr_pkt.info.ecause  = trc_ecause[5*int'(arb_idx) +: 5];
    wr_pkt.info.exc     = trc_exc[arb_idx];
  end

  // ---------------------------------------------------------------- CSR decode
  always_comb begin
    mapped  = 1'b1;
    ro      = 1'b0;
    rdata_v = '0;
    case (reg_addr)
      CSR_CTRL:      rdata_v = {28'b0, 1'b0, trig_en_q, sof_q, state_q != ST_IDLE};
      CSR_STATUS:    begin ro = 1'b1; rdata_v = {27'b0, state_q, wrapped_q, valid_q}; end
      CSR_CONFIG:    begin ro = 1'b1; rdata_v = 32'(NUM_TRACE_ENTRIES * PKT_DWORDS); end
      CSR_WR_PTR:    begin ro = 1'b1; rdata_v = 32'(wr_ptr_q); end
      CSR_RD_PTR:    rdata_v = 32'(rd_ptr_q);
      CSR_DATA:      begin ro = 1'b1; rdata_v = pkt_dword(mem_q[rd_ptr_q[PTR_W-1:2]], rd_ptr_q[1:0]); end
      CSR_TRIG_ADDR: rdata_v = trig_addr_q;
      CSR_POST_CNT:  rdata_v = 32'(post_cnt_q);
      CSR_DROP_CNT:  begin ro = 1'b1; rdata_v = 32'(drop_cnt_q); end
      default:       mapped = 1'b0;
    endcase
  end

  assign csr_ok    = reg_req && debug_en && mapped && !(reg_wr && ro);
  assign wr_ok     = csr_ok && reg_wr;
  assign data_rd   = csr_ok && !reg_wr && (reg_addr == CSR_DATA);
  assign clear_cmd = wr_ok && (reg_addr == CSR_CTRL) && reg_wdata[CTRL_CLEAR];
  assign arm_cmd   = wr_ok && (reg_addr == CSR_CTRL) && reg_wdata[CTRL_ARM];

  assign reg_err   = reg_req && (!debug_en || !mapped || (reg_wr && ro));
  assign reg_rdata = (csr_ok && !reg_wr) ? rdata_v : 32'b0;

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    valid_d     = valid_q;
    wrapped_d   = wrapped_q;
    sof_d       = sof_q;
    trig_en_d   = trig_en_q;
    trig_addr_d = trig_addr_q;
    post_cnt_d  = post_cnt_q;
    post_ctr_d  = post_ctr_q;
    drop_cnt_d  = drop_cnt_q;
    trig_hit_d  = 1'b0;
    drop_sum    = {1'b0, drop_cnt_q} + (DROP_CNT_W + 1)'(arb_drop);

    if (wr_ok) begin
      case (reg_addr)
        CSR_CTRL: begin
          sof_d     = reg_wdata[CTRL_STOP_ON_FULL];
          trig_en_d = reg_wdata[CTRL_TRIG_EN];
        end
        CSR_RD_PTR:    rd_ptr_d    = reg_wdata[PTR_W-1:0];
        CSR_TRIG_ADDR: trig_addr_d = reg_wdata;
        CSR_POST_CNT:  post_cnt_d  = reg_wdata[15:0];
        default: ;
      endcase
    end

    if (data_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (wr_en) begin
      // Pointer always advances modulo depth; only a stop-on-full capture
      // refrains from flagging the wrap.
      wr_ptr_d   = wr_ptr_q + PTR_W'(4);
      valid_d    = 1'b1;
      drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      if (last_slot && !(sof_q && state_q == ST_CAPTURE)) wrapped_d = 1'b1;
      case (state_q)
        ST_ARMED: begin
          if (wr_pkt.addr == trig_addr_q) begin
            trig_hit_d = 1'b1;
            post_ctr_d = post_cnt_q;
            state_d    = (post_cnt_q == 16'd0) ? ST_STOPPED : ST_POST;
          end
        end
        ST_POST: begin
          post_ctr_d = post_ctr_q - 16'd1;
          if (post_ctr_q == 16'd1) state_d = ST_STOPPED;
        end
        ST_CAPTURE: if (sof_q && last_slot) state_d = ST_STOPPED;
        default: ;
      endcase
    end

    // Arm uses the trig_en value written in the same access
    if (state_q == ST_IDLE && arm_cmd)
      state_d = reg_wdata[CTRL_TRIG_EN] ? ST_ARMED : ST_CAPTURE;

    if (clear_cmd) begin
      state_d    = ST_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      valid_d    = 1'b0;
      wrapped_d  = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      valid_q     <= 1'b0;
      wrapped_q   <= 1'b0;
      sof_q       <= 1'b0;
      trig_en_q   <= 1'b0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      post_ctr_q  <= '0;
      drop_cnt_q  <= '0;
      trig_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      valid_q     <= valid_d;
      wrapped_q   <= wrapped_d;
      sof_q       <= sof_d;
      trig_en_q   <= trig_en_d;
      trig_addr_q <= trig_addr_d;
      post_cnt_q  <= post_cnt_d;
      post_ctr_q  <= post_ctr_d;
      drop_cnt_q  <= drop_cnt_d;
      trig_hit_q  <= trig_hit_d;
    end
  end

  // NOTE: the buffer is built from flops with reset because reads after reset
  // must return zeros; a clear deliberately leaves contents untouched.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_TRACE_ENTRIES; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_slot] <= wr_pkt;
    end
  end

  assign trig_hit     = trig_hit_q;
  assign capture_done = (state_q == ST_STOPPED);

endmodule

// File: tb/tb_mci_mcu_mc_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_mci_mcu_mc_trace_buffer
// Directed bench for mci_mcu_mc_trace_buffer (2 channels, 64 entries).
// -----------------------------------------------------------------------------
module tb_mci_mcu_mc_trace_buffer;

  localparam int NCH = 2;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             debug_en = 1'b1;
  logic [NCH-1:0]   trc_valid = '0;
  logic [NCH*32-1:0] trc_insn = '0, trc_addr = '0, trc_tval = '0;
  logic [NCH-1:0]   trc_exc = '0, trc_intr = '0;
  logic [NCH*5-1:0] trc_ecause = '0;
  logic             reg_req = 1'b0, reg_wr = 1'b0;
  logic [5:0]       reg_addr = '0;
  logic [31:0]      reg_wdata = '0;
  logic [31:0]      reg_rdata;
  logic             reg_err, trig_hit, capture_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mci_mcu_mc_trace_buffer #(
    .NUM_CHANNELS(NCH), .NUM_TRACE_ENTRIES(64), .PKT_DWORDS(4), .DROP_CNT_W(16)
  ) dut (
    .clk(clk), .rst_b(rst_b), .debug_en(debug_en),
    .trc_valid(trc_valid), .trc_insn(trc_insn), .trc_addr(trc_addr),
    .trc_tval(trc_tval), .trc_exc(trc_exc), .trc_ecause(trc_ecause),
    .trc_intr(trc_intr), .reg_req(reg_req), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_err(reg_err), .trig_hit(trig_hit), .capture_done(capture_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge
  task automatic csr_wr(input logic [5:0] a, input logic [31:0] d);
    reg_req = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_req = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic csr_rd(input logic [5:0] a, output logic [31:0] d, output logic e);
    reg_req = 1'b1; reg_wr = 1'b0; reg_addr = a;
    #1; d = reg_rdata; e = reg_err;
    @(posedge clk); #1;
    reg_req = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    csr_rd(a, d, e);
    check(tag, d, exp);
  endtask

  task automatic set_ch(input int ch, input logic [31:0] insn, input logic [31:0] addr,
                        input logic [31:0] tval, input logic intr, input logic [4:0] ec,
                        input logic exc);
    trc_valid[ch]         = 1'b1;
    trc_insn[ch*32 +: 32] = insn;
    trc_addr[ch*32 +: 32] = addr;
    trc_tval[ch*32 +: 32] = tval;
    trc_intr[ch]          = intr;
    trc_ecause[ch*5 +: 5] = ec;
    trc_exc[ch]           = exc;
  endtask

  task automatic send(input logic [31:0] insn, input logic [31:0] addr, input logic [31:0] tval);
    trc_valid = '0;
    set_ch(0, insn, addr, tval, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    trc_valid = '0;
  endtask

  task automatic send2(input int k);
    trc_valid = '0;
    set_ch(0, 32'hD000_0000 + k, 32'h100 + k, 32'hB000_0000 + k, 1'b0, 5'd0, 1'b0);
    set_ch(1, 32'hE000_0000 + k, 32'h200 + k, 32'hF000_0000 + k, 1'b1, 5'h1F, 1'b1);
    @(posedge clk); #1;
    trc_valid = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;

    // ---------------- reset state
    #12;
    check("rst_rdata", reg_rdata, 32'h0);
    check("rst_err", {31'b0, reg_err}, 32'h0);
    check("rst_trig_hit", {31'b0, trig_hit}, 32'h0);
    check("rst_done", {31'b0, capture_done}, 32'h0);
    rst_b = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_status", 6'h04, 32'h0);
    rd_chk("rst_wr_ptr", 6'h0C, 32'h0);
    rd_chk("rst_drop", 6'h20, 32'h0);
    rd_chk("config", 6'h08, 32'd256);
    rd_chk("rst_data", 6'h14, 32'h0);
    rd_chk("rd_ptr_autoinc", 6'h10, 32'h1);

    // ---------------- wrap mode, 65 packets
    csr_wr(6'h00, 32'h1);
    rd_chk("armed_capture", 6'h04, 32'h8);
    for (int i = 0; i < 65; i++) send(32'hA000_0000 + i, 32'(i), 32'hB000_0000 + i);
    rd_chk("wrap_status", 6'h04, 32'hB);
    rd_chk("wrap_wr_ptr", 6'h0C, 32'd4);
    csr_wr(6'h10, 32'h0);
    rd_chk("wrap_s0_d0", 6'h14, 32'hA000_0040);
    rd_chk("wrap_s0_d1", 6'h14, 32'h0000_0040);
    rd_chk("wrap_s0_d2", 6'h14, 32'hB000_0040);
    rd_chk("wrap_s0_d3", 6'h14, 32'h0);
    rd_chk("wrap_rd_ptr", 6'h10, 32'd4);
    rd_chk("wrap_s1_d0", 6'h14, 32'hA000_0001);

    // ---------------- stop on full, 70 packets
    csr_wr(6'h00, 32'h8);
    rd_chk("clr_status", 6'h04, 32'h0);
    rd_chk("clr_rd_ptr", 6'h10, 32'h0);
    csr_wr(6'h00, 32'h3);
    for (int i = 0; i < 70; i++) send(32'hC000_0000 + i, 32'h1000 + i, 32'h0);
    rd_chk("sof_status", 6'h04, 32'h11);
    rd_chk("sof_wr_ptr", 6'h0C, 32'h0);
    check("sof_done", {31'b0, capture_done}, 32'h1);
    rd_chk("sof_s0_d0", 6'h14, 32'hC000_0000);
    csr_wr(6'h10, 32'd252);
    rd_chk("sof_s63_d0", 6'h14, 32'hC000_003F);

    // ---------------- trigger + post count
    csr_wr(6'h00, 32'h8);
    check("clr_done", {31'b0, capture_done}, 32'h0);
    csr_wr(6'h18, 32'h8000_0100);
    csr_wr(6'h1C, 32'd3);
    csr_wr(6'h00, 32'h5);
    rd_chk("trig_armed", 6'h04, 32'h4);
    send(32'h7000_0000, 32'h8000_00F0, 32'h0);
    check("trig_pre", {31'b0, trig_hit}, 32'h0);
    send(32'h7000_0001, 32'h8000_0100, 32'h0);
    check("trig_pulse", {31'b0, trig_hit}, 32'h1);
    for (int j = 2; j < 7; j++) begin
      send(32'h7000_0000 + j, 32'h8000_0200 + j, 32'h0);
      if (j == 2) check("trig_pulse_end", {31'b0, trig_hit}, 32'h0);
    end
    rd_chk("post_status", 6'h04, 32'h11);
    rd_chk("post_wr_ptr", 6'h0C, 32'd20);
    csr_wr(6'h10, 32'd16);
    rd_chk("post_s4_d0", 6'h14, 32'h7000_0004);
    csr_wr(6'h10, 32'd20);
    rd_chk("post_s5_untouched", 6'h14, 32'hC000_0005);

    // ---------------- round-robin arbitration
    csr_wr(6'h00, 32'h8);
    csr_wr(6'h00, 32'h1);
    for (int k = 0; k < 4; k++) send2(k);
    rd_chk("arb_drop", 6'h20, 32'd4);
    rd_chk("arb_wr_ptr", 6'h0C, 32'd16);

    // ---------------- readback of first two packets
    csr_wr(6'h10, 32'h0);
    rd_chk("rd_s0_d0", 6'h14, 32'hD000_0000);
    rd_chk("rd_s0_d1", 6'h14, 32'h0000_0100);
    rd_chk("rd_s0_d2", 6'h14, 32'hB000_0000);
    rd_chk("rd_s0_d3", 6'h14, 32'h0);
    rd_chk("rd_s1_d0", 6'h14, 32'hE000_0001);
    rd_chk("rd_s1_d1", 6'h14, 32'h0000_0201);
    rd_chk("rd_s1_d2", 6'h14, 32'hF000_0001);
    rd_chk("rd_s1_d3", 6'h14, 32'h0000_00FF);
    rd_chk("rd_ptr8", 6'h10, 32'd8);
    rd_chk("rd_s2_d0", 6'h14, 32'hD000_0002);
    csr_wr(6'h10, 32'd12);
    rd_chk("rd_s3_d0", 6'h14, 32'hE000_0003);

    // ---------------- error cases
    debug_en = 1'b0;
    csr_rd(6'h14, d, e);
    check("dbg_off_rdata", d, 32'h0);
    check("dbg_off_err", {31'b0, e}, 32'h1);
    debug_en = 1'b1;
    rd_chk("dbg_off_rd_ptr", 6'h10, 32'd13);
    csr_rd(6'h24, d, e);
    check("unmapped_err", {31'b0, e}, 32'h1);
    check("unmapped_rdata", d, 32'h0);
    reg_req = 1'b1; reg_wr = 1'b1; reg_addr = 6'h04; reg_wdata = 32'hFFFF_FFFF;
    #1; check("ro_wr_err", {31'b0, reg_err}, 32'h1);
    @(posedge clk); #1; reg_req = 1'b0; reg_wr = 1'b0;
    rd_chk("ro_wr_no_effect", 6'h04, 32'h9);
    csr_wr(6'h10, 32'h1FF);
    rd_chk("rd_ptr_mask", 6'h10, 32'hFF);

    // ---------------- async reset during POST
    csr_wr(6'h00, 32'h8);
    csr_wr(6'h00, 32'h5);
    send(32'h6000_0000, 32'h8000_0100, 32'h0);
    rd_chk("post2_status", 6'h04, 32'hD);
    send2(9);
    rd_chk("post2_drop", 6'h20, 32'd1);
    send(32'h6000_0001, 32'h8000_0300, 32'h0);
    rst_b = 1'b0;
    #2;
    check("mid_rst_rdata", reg_rdata, 32'h0);
    check("mid_rst_err", {31'b0, reg_err}, 32'h0);
    check("mid_rst_trig", {31'b0, trig_hit}, 32'h0);
    check("mid_rst_done", {31'b0, capture_done}, 32'h0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rd_chk("post_rst_status", 6'h04, 32'h0);
    rd_chk("post_rst_drop", 6'h20, 32'h0);

    // ---------------- clear while capturing
    csr_wr(6'h00, 32'h1);
    rd_chk("cap_status", 6'h04, 32'h8);
    send(32'h5000_0000, 32'h10, 32'h0);
    send(32'h5000_0001, 32'h14, 32'h0);
    rd_chk("cap_wr_ptr", 6'h0C, 32'd8);
    csr_wr(6'h10, 32'd5);
    csr_wr(6'h00, 32'h8);
    rd_chk("cap_clr_status", 6'h04, 32'h0);
    rd_chk("cap_clr_wr_ptr", 6'h0C, 32'h0);
    rd_chk("cap_clr_rd_ptr", 6'h10, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mci_mcu_mc_trace_buffer.md
Name: mci_mcu_mc_trace_buffer

Overview:
Multi-channel, parametrised trace capture buffer in MCI that records retired-instruction trace packets from up to NUM_CHANNELS MCU trace ports. It adds a capture state machine with address-match trigger, post-trigger count, and wrap or stop-on-full modes. It also arbitrates simultaneous packets round-robin with a saturating drop counter and auto-increments the read pointer on DATA reads. Register access is a single-cycle CSR port, qualified by debug_en.

Parameters:
NUM_CHANNELS, 2, trace sources (1..4)
NUM_TRACE_ENTRIES, 64, packet slots (power of 2, >=4)
PKT_DWORDS, 4, dwords per packet (fixed 4; dword ptr = entry<<2 | offset)
DROP_CNT_W, 16, drop counter width

Ports:
clk  in  1  clock
rst_b  in  1  async active-low reset
debug_en  in  1  gates all CSR access and trace capture
trc_valid  in  NUM_CHANNELS  per-channel packet valid
trc_insn  in  NUM_CHANNELS*32  instruction
trc_addr  in  NUM_CHANNELS*32  PC
trc_tval  in  NUM_CHANNELS*32  trap value
trc_exc  in  NUM_CHANNELS  exception
trc_ecause  in  NUM_CHANNELS*5  exception cause
trc_intr  in  NUM_CHANNELS  interrupt
reg_req  in  1  CSR request
reg_wr  in  1  write when 1
reg_addr  in  6  byte address
reg_wdata  in  32  write data
reg_rdata  out  32  read data, same cycle
reg_err  out  1  error, same cycle
trig_hit  out  1  one-cycle pulse on trigger match
capture_done  out  1  level, high in STOPPED

Behaviour:
- Reset: all outputs 0. FSM=IDLE, pointers/counters 0, buffer contents 0.
- Packet, dword0..3: insn, addr, tval, {23'b0, chan_id[1:0], intr, ecause[4:0], exc}.
- CSR map:
  - 0x00 CTRL: [0]arm (W1S), [1]stop_on_full, [2]trig_en, [3]clear (W1P).
  - 0x04 STATUS RO: [0]valid, [1]wrapped, [4:2]state.
  - 0x08 CONFIG RO: NUM_TRACE_ENTRIES*4.
  - 0x0C WR_PTR RO.
  - 0x10 RD_PTR RW.
  - 0x14 DATA RO.
  - 0x18 TRIG_ADDR RW.
  - 0x1C POST_CNT RW, 16b.
  - 0x20 DROP_CNT RO.
- reg_err=1 when: unmapped addr, write to RO, reg_req while debug_en=0 (rdata=0, no side effect).
- FSM (3b enc):
  - IDLE(0) -arm-> ARMED(1) if trig_en, else CAPTURE(2).
  - ARMED: records like CAPTURE; a granted packet with addr==TRIG_ADDR pulses trig_hit next cycle and goes to POST(3) with post counter loaded with POST_CNT.
  - POST: each written packet decrements the counter; write of the packet that makes it 0 -> STOPPED(4). POST_CNT=0 -> STOPPED right after the trigger packet.
  - CAPTURE: stop_on_full and last slot written -> STOPPED.
  - STOPPED: no writes.
  - clear from any state -> IDLE, pointers/valid/wrapped/DROP_CNT=0. Buffer contents are not cleared.
  - debug_en=0 suppresses writes; state is held.
- Arbitration: one write/cycle. Round-robin pointer starts at ch0 and advances past the winner. Each losing valid channel increments DROP_CNT, saturating at all-ones; simultaneous losers are added in the same cycle.
- Write: at slot wr_ptr>>2, wr_ptr += 4. At last slot: wr_ptr->0 and wrapped=1, unless stop_on_full (ptr holds at last+4 wrapped to 0, wrapped stays 0). valid=1 on first write.
- Read: DATA = buffer[rd_ptr>>2][rd_ptr[1:0]] combinational. Each successful DATA read increments rd_ptr modulo depth*4, effective next cycle. A CSR write to RD_PTR in the same cycle as a DATA read cannot occur (single port).
- Out-of-range RD_PTR writes are masked to the log2(depth*4) bits.

Decomposition:
- Package mci_mcu_mc_trace_buffer_pkg: packet struct, FSM enum, CSR offset localparams, CTRL bit positions.
- Sub-module mci_trace_rr_arb: NUM_CHANNELS round-robin arbiter giving one-hot grant, grant index and a drop count.

Test Plan:
- Arm with trig_en=0, stop_on_full=0, 65 packets on ch0 -> wrapped=1, WR_PTR=4, slot0 holds packet 64.
- stop_on_full=1, 70 packets -> STOPPED after 64, WR_PTR=0, capture_done=1, entries 64..69 absent.
- TRIG_ADDR=0x8000_0100, POST_CNT=3; addr stream 0xF0,0x100,... -> trig_hit one cycle, exactly 3 more packets written, state=4.
- Both channels valid 4 consecutive cycles -> grants alternate ch0,ch1,ch0,ch1, DROP_CNT=4, chan_id field matches the winner.
- RD_PTR=0, 8 DATA reads -> first two packets returned in dword order, RD_PTR=8. With debug_en=0 a DATA read returns 0 with reg_err=1 and RD_PTR unchanged.
- Assert rst_b mid-POST -> all outputs 0, state IDLE, DROP_CNT 0. Write clear in CAPTURE -> IDLE with pointers 0.
